// File: rtl/cnt_modn_chain.sv
// Cascaded modulo-N counter chain with up/down counting, synchronous load and
// clear, per-digit terminal flags, a cascade carry and a registered wrap pulse.
//
// Parameters:
//   MODULUS  count range per digit 0..MODULUS-1 (2..2**WIDTH)
//   WIDTH    bits per digit (2**WIDTH >= MODULUS)
//   NDIGITS  number of chained digits (1..8)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enable     count enable for digit 0
//   up_dn      1 = count up, 0 = count down
//   clear      synchronous clear to all-zero (highest priority)
//   load       synchronous parallel load of load_val (clamped per digit)
//   load_val   load value, digit i at [i*WIDTH +: WIDTH]
//   count      registered digit values, same packing as load_val
//   digit_tc   combinational, bit i = digit i at its terminal value
//   carry_out  combinational, enable & all digits terminal
//   wrap_pulse registered, one cycle after a full-chain wrap
//   load_err   registered, one cycle after a load that clamped a digit

module cnt_modn_chain #(
   parameter int unsigned MODULUS = 10,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned NDIGITS = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       up_dn,
   input  logic                       clear,
   input  logic                       load,
   input  logic [NDIGITS*WIDTH-1:0]   load_val,
   output logic [NDIGITS*WIDTH-1:0]   count,
   output logic [NDIGITS-1:0]         digit_tc,
   output logic                       carry_out,
   output logic                       wrap_pulse,
   output logic                       load_err
);

   localparam int unsigned CW = NDIGITS * WIDTH;
   localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);

   logic [CW-1:0]      count_nxt;
   logic               wrap_nxt;
   logic               err_nxt;
   logic [NDIGITS:0]   chain;
   logic [WIDTH-1:0]   lv;
   logic [WIDTH-1:0]   d_cur;

   // Terminal flags and ripple step-enables: chain[i] = digit i steps this edge.
   always_comb begin
      digit_tc = '0;
      chain    = '0;
      chain[0] = enable;
      for (int i = 0; i < NDIGITS; i++) begin
         if (up_dn) begin
            digit_tc[i] = (count[i*WIDTH +: WIDTH] == DMAX);
         end else begin
            digit_tc[i] = (count[i*WIDTH +: WIDTH] == '0);
         end
         chain[i+1] = chain[i] & digit_tc[i];
      end
   end

   assign carry_out = chain[NDIGITS];

   // Next-state: clear > load > counting.
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      err_nxt   = 1'b0;
      lv        = '0;
      d_cur     = '0;
      if (clear) begin
         count_nxt = '0;
      end else if (load) begin
         for (int i = 0; i < NDIGITS; i++) begin
            lv = load_val[i*WIDTH +: WIDTH];
            // Out-of-range digits saturate at the top of the digit range.
            if (32'(lv) >= MODULUS) begin
               count_nxt[i*WIDTH +: WIDTH] = DMAX;
               err_nxt = 1'b1;
            end else begin
               count_nxt[i*WIDTH +: WIDTH] = lv;
            end
         end
      end else begin
         for (int i = 0; i < NDIGITS; i++) begin
            d_cur = count[i*WIDTH +: WIDTH];
            if (chain[i]) begin
               if (up_dn) begin
                  count_nxt[i*WIDTH +: WIDTH] = (d_cur == DMAX) ? '0 : d_cur + WIDTH'(1);
               end else begin
                  count_nxt[i*WIDTH +: WIDTH] = (d_cur == '0) ? DMAX : d_cur - WIDTH'(1);
               end
            end
         end
         wrap_nxt = carry_out;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         wrap_pulse <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         count      <= count_nxt;
         wrap_pulse <= wrap_nxt;
         load_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_cnt_modn_chain.sv
// Directed bench for cnt_modn_chain: default decade chain plus a MODULUS=6,
// NDIGITS=3 instance for the parameter sweep.
`timescale 1ns/1ps
module tb_cnt_modn_chain;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, up_dn, clear, load;
   logic [7:0]  load_val;
   logic [7:0]  count;
   logic [1:0]  digit_tc;
   logic        carry_out, wrap_pulse, load_err;

   logic        enable6;
   logic [11:0] count6;
   logic [2:0]  tc6;
   logic        carry6, wrap6, err6;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cnt_modn_chain #(.MODULUS(10), .WIDTH(4), .NDIGITS(2)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
      .load(load), .load_val(load_val), .count(count), .digit_tc(digit_tc),
      .carry_out(carry_out), .wrap_pulse(wrap_pulse), .load_err(load_err)
   );

   cnt_modn_chain #(.MODULUS(6), .WIDTH(4), .NDIGITS(3)) u_dut6 (
      .clk(clk), .reset(reset), .enable(enable6), .up_dn(1'b1), .clear(1'b0),
      .load(1'b0), .load_val(12'h000), .count(count6), .digit_tc(tc6),
      .carry_out(carry6), .wrap_pulse(wrap6), .load_err(err6)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] bcd(input int k);
      return 8'(((k / 10) % 10) * 16 + (k % 10));
   endfunction

   initial begin
      int last_tc;
      int n_tc;
      int n_wrap6;

      reset = 1'b0; enable = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
      load_val = 8'h00; enable6 = 1'b0;

      // Power-on reset state
      #12;
      check("rst_count", count, 8'h00);
      check("rst_wrap", wrap_pulse, 0);
      check("rst_err", load_err, 0);
      reset = 1'b1;
      tick();

      // T1: asynchronous reset mid-count at 0x37
      load = 1'b1; load_val = 8'h36;
      tick();
      load = 1'b0; enable = 1'b1;
      tick();
      check("t1_pre", count, 8'h37);
      #2 reset = 1'b0;
      #1;
      check("t1_count", count, 8'h00);
      check("t1_wrap", wrap_pulse, 0);
      check("t1_err", load_err, 0);
      enable = 1'b0;
      reset = 1'b1;
      tick();
      check("t1_after", count, 8'h00);

      // T2: count up through the full range and wrap
      enable = 1'b1; up_dn = 1'b1;
      for (int k = 0; k < 100; k++) begin
         check("t2_count", count, bcd(k));
         check("t2_carry", carry_out, (k == 99) ? 1 : 0);
         tick();
         check("t2_wrap", wrap_pulse, (k == 99) ? 1 : 0);
      end
      check("t2_end", count, 8'h00);
      tick();
      check("t2_wrap_off", wrap_pulse, 0);
      check("t2_next", count, 8'h01);
      enable = 1'b0;

      // T3: count down through zero
      load = 1'b1; load_val = 8'h01;
      tick();
      load = 1'b0;
      check("t3_load", count, 8'h01);
      check("t3_err", load_err, 0);
      up_dn = 1'b0; enable = 1'b1;
      #1;
      check("t3_carry0", carry_out, 0);
      tick();
      check("t3_c00", count, 8'h00);
      check("t3_tc", digit_tc, 2'b11);
      check("t3_carry", carry_out, 1);
      tick();
      check("t3_c99", count, 8'h99);
      check("t3_wrap", wrap_pulse, 1);
      tick();
      check("t3_c98", count, 8'h98);
      check("t3_wrap_off", wrap_pulse, 0);
      enable = 1'b0;
      tick();
      check("t3_hold", count, 8'h98);

      // T4: load clamp and up_dn reversal
      up_dn = 1'b1;
      load = 1'b1; load_val = 8'hC5;
      tick();
      load = 1'b0;
      check("t4_clamp", count, 8'h95);
      check("t4_err", load_err, 1);
      tick();
      check("t4_err_off", load_err, 0);
      check("t4_hold", count, 8'h95);
      load = 1'b1; load_val = 8'h42;
      tick();
      load = 1'b0;
      check("t4_ok", count, 8'h42);
      check("t4_ok_err", load_err, 0);
      enable = 1'b1;
      tick();
      check("t4_up", count, 8'h43);
      up_dn = 1'b0;
      tick();
      check("t4_dn", count, 8'h42);
      up_dn = 1'b1;
      tick();
      check("t4_up2", count, 8'h43);
      enable = 1'b0;

      // T5: priority clear > load > enable
      load = 1'b1; load_val = 8'h45;
      tick();
      check("t5_pre", count, 8'h45);
      clear = 1'b1; load = 1'b1; enable = 1'b1; load_val = 8'hCC;
      tick();
      check("t5_clear", count, 8'h00);
      check("t5_clear_err", load_err, 0);
      check("t5_clear_wrap", wrap_pulse, 0);
      clear = 1'b0; load_val = 8'h12;
      tick();
      check("t5_load", count, 8'h12);
      load = 1'b0;
      tick();
      check("t5_count", count, 8'h13);
      enable = 1'b0;

      // T6: MODULUS=6, NDIGITS=3 sweep
      check("t6_start", count6, 12'h000);
      last_tc = -1; n_tc = 0; n_wrap6 = 0;
      enable6 = 1'b1;
      for (int k = 0; k < 216; k++) begin
         check("t6_count", count6, 12'((k / 36) * 256 + ((k / 6) % 6) * 16 + (k % 6)));
         check("t6_carry", carry6, (k == 215) ? 1 : 0);
         if (tc6[0]) begin
            if (last_tc >= 0) check("t6_tc_period", k - last_tc, 6);
            last_tc = k;
            n_tc++;
         end
         tick();
         if (wrap6) n_wrap6++;
      end
      enable6 = 1'b0;
      check("t6_wraps", n_wrap6, 1);
      check("t6_tc_count", n_tc, 36);
      check("t6_end", count6, 12'h000);
      check("t6_err", err6, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
